// File: rtl/uart_rx_unit_if.sv
// Receive-side handshake bundle between uart_rx_unit (master) and its consumer (slave).
// parity_err is present only when UART_RX_PARITY_EN is defined.
interface uart_rx_unit_if #(parameter int DBIT = 8);
  logic            rd_uart;
  logic [DBIT-1:0] r_data;
  logic            rx_empty;
  logic            rx_done_tick;
  logic            frame_err;
  logic            overrun;
  logic            busy;
`ifdef UART_RX_PARITY_EN
  logic            parity_err;
`endif

  modport master (
    input  rd_uart,
    output r_data, rx_empty, rx_done_tick, frame_err, overrun, busy
`ifdef UART_RX_PARITY_EN
    , output parity_err
`endif
  );

  modport slave (
    output rd_uart,
    input  r_data, rx_empty, rx_done_tick, frame_err, overrun, busy
`ifdef UART_RX_PARITY_EN
    , input parity_err
`endif
  );
endinterface

// File: rtl/uart_rx_unit.sv
// 16x oversampled 8N1 UART receiver with a one-entry holding register.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err flag.
//
// state  | meaning
// IDLE   | line idle; arms once rx_s is seen high, leaves on a low rx_s
// START  | counting to mid start bit; high there means glitch
// DATA   | sampling DBIT data bits, LSB first, every 16 ticks
// PARITY | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP   | waiting SB_TICK ticks, then judging the stop bit
module uart_rx_unit #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic s_tick,
  input  logic rx,
  uart_rx_unit_if.master bus
);
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state, state_n;
  logic            rx_m, rx_s;
  logic [3:0]      s_cnt, s_cnt_n;
  logic [NW-1:0]   n_cnt, n_cnt_n;
  logic [DBIT-1:0] b_reg, b_reg_n;
  logic            armed, armed_n;
  logic            done, stop_ok, good, load, ov_set;
  logic [DBIT-1:0] r_data_q;
  logic            rx_empty_q, frame_err_q, overrun_q;
`ifdef UART_RX_PARITY_EN
  logic            par_bad, par_bad_n, parity_err_q;
  assign good = ~par_bad;
`else
  assign good = 1'b1;
`endif

  always_comb begin
    state_n = state;
    s_cnt_n = s_cnt;
    n_cnt_n = n_cnt;
    b_reg_n = b_reg;
    armed_n = armed;
    done    = 1'b0;
    stop_ok = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_n = par_bad;
`endif
    case (state)
      IDLE: begin
        // a break leaves the line low on return; wait for it to go high first
        if (rx_s) armed_n = 1'b1;
        else if (armed) begin
          state_n = START;
          s_cnt_n = 4'd0;
        end
      end
      START: if (s_tick) begin
        if (s_cnt == 4'd7) begin
          if (!rx_s) begin
            state_n = DATA;
            s_cnt_n = 4'd0;
            n_cnt_n = '0;
          end else state_n = IDLE;
        end else s_cnt_n = s_cnt + 4'd1;
      end
      DATA: if (s_tick) begin
        if (s_cnt == 4'd15) begin
          b_reg_n = {rx_s, b_reg[DBIT-1:1]};
          s_cnt_n = 4'd0;
          if (n_cnt == NW'(DBIT-1)) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else n_cnt_n = n_cnt + 1'b1;
        end else s_cnt_n = s_cnt + 4'd1;
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (s_tick) begin
        if (s_cnt == 4'd15) begin
          par_bad_n = ^{rx_s, b_reg};
          state_n   = STOP;
          s_cnt_n   = 4'd0;
        end else s_cnt_n = s_cnt + 4'd1;
      end
`endif
      STOP: if (s_tick) begin
        if (s_cnt == 4'(SB_TICK-1)) begin
          state_n = IDLE;
          done    = 1'b1;
          stop_ok = rx_s;
          armed_n = rx_s;
        end else s_cnt_n = s_cnt + 4'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  assign load   = done & stop_ok & good;
  assign ov_set = load & ~rx_empty_q & ~bus.rd_uart;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m        <= 1'b1;
      rx_s        <= 1'b1;
      state       <= IDLE;
      s_cnt       <= '0;
      n_cnt       <= '0;
      b_reg       <= '0;
      armed       <= 1'b0;
      r_data_q    <= '0;
      rx_empty_q  <= 1'b1;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad      <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_m  <= rx;
      rx_s  <= rx_m;
      state <= state_n;
      s_cnt <= s_cnt_n;
      n_cnt <= n_cnt_n;
      b_reg <= b_reg_n;
      armed <= armed_n;
      if (load) begin
        r_data_q   <= b_reg;
        rx_empty_q <= 1'b0;
      end else if (bus.rd_uart) rx_empty_q <= 1'b1;
      // sticky flags: a set in the same clk as rd_uart wins
      frame_err_q <= (done & ~stop_ok) | (frame_err_q & ~bus.rd_uart);
      overrun_q   <= ov_set | (overrun_q & ~bus.rd_uart);
`ifdef UART_RX_PARITY_EN
      par_bad      <= par_bad_n;
      parity_err_q <= (done & par_bad) | (parity_err_q & ~bus.rd_uart);
`endif
    end
  end

  assign bus.r_data       = r_data_q;
  assign bus.rx_empty     = rx_empty_q;
  assign bus.rx_done_tick = done;
  assign bus.frame_err    = frame_err_q;
  assign bus.overrun      = overrun_q;
  assign bus.busy         = (state != IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err   = parity_err_q;
`endif
endmodule

// File: tb/tb_uart_rx_unit.sv
// Self-checking bench for uart_rx_unit: serial frames are driven on rx, expected
// outcomes are queued per frame and compared when rx_done_tick fires.
module tb_uart_rx_unit;
  localparam int BIT_CLK = 64;  // 4 clk per s_tick, 16 ticks per bit

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic s_tick = 1'b0;
  logic rx = 1'b1;
  int   tdiv = 0;

  uart_rx_unit_if #(.DBIT(8)) bus ();

  uart_rx_unit #(.DBIT(8), .SB_TICK(16)) dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      tdiv   = tdiv + 1;
      s_tick = ((tdiv % 4) == 0);
    end
  end

  typedef struct {
    logic [7:0] d;
    int         kind;  // 0 loaded, 1 frame error, 2 parity error
  } exp_t;

  exp_t sb[$];
  int   nchk = 0;
  int   nerr = 0;
  int   done_cnt = 0;
  bit   pend = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk = nchk + 1;
    if (got !== exp) begin
      nerr = nerr + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard monitor: result of a frame is visible one clk after rx_done_tick
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (pend) begin
        pend = 0;
        if (sb.size() == 0) check("sb_unexpected_done", 1, 0);
        else begin
          e = sb.pop_front();
          case (e.kind)
            0: begin
              check("sb_data", bus.r_data, e.d);
              check("sb_loaded", bus.rx_empty, 0);
            end
            1: check("sb_frame_err", bus.frame_err, 1);
            default: begin
`ifdef UART_RX_PARITY_EN
              check("sb_parity_err", bus.parity_err, 1);
`endif
            end
          endcase
        end
      end
      if (bus.rx_done_tick === 1'b1) begin
        done_cnt = done_cnt + 1;
        pend = 1;
      end
    end
  end

  task automatic tick_clk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic bit_out(input logic v);
    rx = v;
    tick_clk(BIT_CLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_out(par);
`endif
    bit_out(stop);
    rx = 1'b1;
    tick_clk(32);
  endtask

  task automatic push(input logic [7:0] d, input int kind);
    exp_t e;
    e.d = d;
    e.kind = kind;
    sb.push_back(e);
  endtask

  task automatic wait_sb();
    for (int i = 0; i < 400; i++) begin
      if (sb.size() == 0 && !pend) break;
      @(negedge clk);
    end
    check("sb_drained", sb.size() + int'(pend), 0);
    tick_clk(1);
  endtask

  task automatic pulse_rd();
    tick_clk(1);
    bus.rd_uart = 1'b1;
    tick_clk(1);
    bus.rd_uart = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int  done0;
    bit  seen;
    bus.rd_uart = 1'b0;
    tick_clk(4);
    @(negedge clk);
    check("rst_r_data", bus.r_data, 0);
    check("rst_empty", bus.rx_empty, 1);
    check("rst_ferr", bus.frame_err, 0);
    check("rst_ovr", bus.overrun, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.rx_done_tick, 0);
    reset = 1'b0;
    tick_clk(20);

    // good frame, then pop it
    done0 = done_cnt;
    push(8'hA5, 0);
    send_frame(8'hA5, 1'b1, 1'b0);
    wait_sb();
    check("a5_one_done", done_cnt - done0, 1);
    check("a5_ferr", bus.frame_err, 0);
    pulse_rd();
    check("a5_rd_empty", bus.rx_empty, 1);
    check("a5_rd_keep", bus.r_data, 8'hA5);

    // short low glitch
    done0 = done_cnt;
    rx = 1'b0;
    tick_clk(10);
    @(negedge clk);
    check("glitch_busy_hi", bus.busy, 1);
    tick_clk(6);
    rx = 1'b1;
    tick_clk(100);
    @(negedge clk);
    check("glitch_busy_lo", bus.busy, 0);
    check("glitch_no_done", done_cnt - done0, 0);
    check("glitch_ferr", bus.frame_err, 0);
    check("glitch_ovr", bus.overrun, 0);

    // stop bit low
    push(8'h3C, 1);
    send_frame(8'h3C, 1'b0, 1'b0);
    wait_sb();
    check("ferr_empty", bus.rx_empty, 1);
    pulse_rd();
    check("ferr_cleared", bus.frame_err, 0);

    // overrun
    push(8'h11, 0);
    send_frame(8'h11, 1'b1, 1'b0);
    push(8'h22, 0);
    send_frame(8'h22, 1'b1, 1'b0);
    wait_sb();
    check("ovr_data", bus.r_data, 8'h22);
    check("ovr_set", bus.overrun, 1);
    pulse_rd();
    check("ovr_cleared", bus.overrun, 0);
    check("ovr_rd_empty", bus.rx_empty, 1);

    // read coincident with load
    push(8'h11, 0);
    send_frame(8'h11, 1'b1, 1'b0);
    wait_sb();
    push(8'h22, 0);
    seen = 0;
    fork
      send_frame(8'h22, 1'b1, 1'b0);
      begin
        for (int i = 0; i < 2000 && !seen; i++) begin
          @(negedge clk);
          if (bus.rx_done_tick === 1'b1) seen = 1;
        end
        bus.rd_uart = 1'b1;
        tick_clk(1);
        bus.rd_uart = 1'b0;
      end
    join
    wait_sb();
    check("coinc_done_seen", seen, 1);
    check("coinc_data", bus.r_data, 8'h22);
    check("coinc_empty", bus.rx_empty, 0);
    check("coinc_ovr", bus.overrun, 0);

    // reset in data bit 4 of 0xFF
    rx = 1'b0;
    tick_clk(BIT_CLK);
    rx = 1'b1;
    tick_clk(BIT_CLK * 4 + 32);
    @(negedge clk);
    check("mid_busy", bus.busy, 1);
    tick_clk(1);
    reset = 1'b1;
    tick_clk(1);
    reset = 1'b0;
    @(negedge clk);
    check("mrst_r_data", bus.r_data, 0);
    check("mrst_empty", bus.rx_empty, 1);
    check("mrst_busy", bus.busy, 0);
    check("mrst_done", bus.rx_done_tick, 0);
    check("mrst_ferr", bus.frame_err, 0);
    check("mrst_ovr", bus.overrun, 0);
    tick_clk(BIT_CLK * 6);
    done0 = done_cnt;
    push(8'h5A, 0);
    send_frame(8'h5A, 1'b1, 1'b0);
    wait_sb();
    check("post_rst_one_done", done_cnt - done0, 1);
    check("post_rst_data", bus.r_data, 8'h5A);
    pulse_rd();

`ifdef UART_RX_PARITY_EN
    push(8'h07, 0);
    send_frame(8'h07, 1'b1, 1'b1);
    wait_sb();
    check("par_good_err", bus.parity_err, 0);
    pulse_rd();
    push(8'h07, 2);
    send_frame(8'h07, 1'b1, 1'b0);
    wait_sb();
    check("par_bad_empty", bus.rx_empty, 1);
    pulse_rd();
    check("par_cleared", bus.parity_err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
